// File: rtl/move_sequencer.sv
// Motion segment sequencer: buffers segments in a small circular FIFO and feeds
// them to the DDA step timer one at a time, with HALT abort and status outputs.
module move_sequencer #(
  parameter int BUF_BITS = 2,
  parameter int TICK_W   = 32,
  parameter int INC_W    = 32
) (
  input  logic                CLK,
  input  logic                resetn,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [TICK_W-1:0]   wr_ticks,
  input  logic [INC_W-1:0]    wr_inc,
  input  logic [INC_W-1:0]    wr_incinc,
  input  logic                wr_dir,
  input  logic                halt,
  output logic                dda_load,
  output logic [TICK_W-1:0]   dda_ticks,
  output logic [INC_W-1:0]    dda_inc,
  output logic [INC_W-1:0]    dda_incinc,
  output logic                dda_dir,
  output logic                dda_abort,
  input  logic                dda_done,
  output logic                buffer_dtr,
  output logic                move_done,
  output logic                busy,
  output logic [BUF_BITS:0]   fill_level
);

  localparam int DEPTH = 1 << BUF_BITS;
  localparam int W     = TICK_W + 2*INC_W + 1;
  localparam logic [BUF_BITS:0]   CNT_ONE  = 1;
  localparam logic [BUF_BITS:0]   CNT_FULL = {1'b1, {BUF_BITS{1'b0}}};
  localparam logic [BUF_BITS-1:0] PTR_ONE  = 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HALTED} state_e;

  state_e              state_q, state_d;
  logic [W-1:0]        mem_q [DEPTH];
  logic [BUF_BITS-1:0] wptr_q, rptr_q;
  logic [BUF_BITS:0]   count_q, count_d;
  logic                load_q, load_d;
  logic                abort_q, abort_d;
  logic                done_q, done_d;
  logic [TICK_W-1:0]   ticks_q;
  logic [INC_W-1:0]    inc_q, incinc_q;
  logic                dir_q;

  logic                full, empty, push, pop;
  logic [W-1:0]        head;
  logic [TICK_W-1:0]   head_ticks;
  logic [INC_W-1:0]    head_inc, head_incinc;
  logic                head_dir;

  assign full        = (count_q == CNT_FULL);
  assign empty       = (count_q == '0);
  assign wr_ready    = !full && (state_q != HALTED) && !halt;
  assign push        = wr_valid && wr_ready;
  assign pop         = (state_q == LOAD) && !halt;
  assign head        = mem_q[rptr_q];
  assign head_ticks  = head[W-1 -: TICK_W];
  assign head_inc    = head[W-1-TICK_W -: INC_W];
  assign head_incinc = head[INC_W:1];
  assign head_dir    = head[0];

  always_comb begin
    count_d = count_q;
    if (halt)
      count_d = '0;
    else if (push && !pop)
      count_d = count_q + CNT_ONE;
    else if (pop && !push)
      count_d = count_q - CNT_ONE;
  end

  always_comb begin
    state_d = state_q;
    load_d  = 1'b0;
    abort_d = 1'b0;
    done_d  = 1'b0;
    if (halt) begin
      // halt outranks both dda_done and a pending load in the same cycle
      state_d = HALTED;
      abort_d = (state_q == LOAD) || (state_q == RUN);
    end else begin
      case (state_q)
        IDLE:   if (!empty) state_d = LOAD;
        LOAD: begin
          if (head_ticks != '0) begin
            load_d  = 1'b1;
            state_d = RUN;
          end else begin
            state_d = (count_d != '0) ? LOAD : IDLE;
          end
        end
        RUN: begin
          if (dda_done) begin
            done_d  = 1'b1;
            state_d = empty ? IDLE : LOAD;
          end
        end
        HALTED: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wptr_q] <= {wr_ticks, wr_inc, wr_incinc, wr_dir};
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      load_q   <= 1'b0;
      abort_q  <= 1'b0;
      done_q   <= 1'b0;
      ticks_q  <= '0;
      inc_q    <= '0;
      incinc_q <= '0;
      dir_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      load_q  <= load_d;
      abort_q <= abort_d;
      done_q  <= done_d;
      if (halt) begin
        rptr_q <= wptr_q;
      end else begin
        if (push) wptr_q <= wptr_q + PTR_ONE;
        if (pop)  rptr_q <= rptr_q + PTR_ONE;
      end
      if (load_d) begin
        ticks_q  <= head_ticks;
        inc_q    <= head_inc;
        incinc_q <= head_incinc;
        dir_q    <= head_dir;
      end
    end
  end

  assign dda_load   = load_q;
  assign dda_abort  = abort_q;
  assign move_done  = done_q;
  assign dda_ticks  = ticks_q;
  assign dda_inc    = inc_q;
  assign dda_incinc = incinc_q;
  assign dda_dir    = dir_q;
  assign buffer_dtr = !full;
  assign fill_level = count_q;
  assign busy       = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_move_sequencer.sv
// Scoreboard bench for move_sequencer: accepted non-zero segments are queued as
// expected DDA loads; a monitor pops and compares on every dda_load pulse.
module tb_move_sequencer;

  logic        CLK = 1'b0;
  logic        resetn;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_ticks, wr_inc, wr_incinc;
  logic        wr_dir;
  logic        halt;
  logic        dda_load;
  logic [31:0] dda_ticks, dda_inc, dda_incinc;
  logic        dda_dir, dda_abort, dda_done;
  logic        buffer_dtr, move_done, busy;
  logic [2:0]  fill_level;

  logic        done_auto = 1'b0;
  logic        done_man  = 1'b0;
  assign dda_done = done_auto | done_man;

  move_sequencer #(.BUF_BITS(2), .TICK_W(32), .INC_W(32)) dut (
    .CLK(CLK), .resetn(resetn),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_ticks(wr_ticks),
    .wr_inc(wr_inc), .wr_incinc(wr_incinc), .wr_dir(wr_dir),
    .halt(halt),
    .dda_load(dda_load), .dda_ticks(dda_ticks), .dda_inc(dda_inc),
    .dda_incinc(dda_incinc), .dda_dir(dda_dir), .dda_abort(dda_abort),
    .dda_done(dda_done),
    .buffer_dtr(buffer_dtr), .move_done(move_done), .busy(busy),
    .fill_level(fill_level)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] ticks;
    logic [31:0] inc;
    logic [31:0] incinc;
    logic        dir;
  } seg_t;

  seg_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_loads = 0, n_done = 0, n_abort = 0;

  // DDA stand-in: answers each load with dda_done after a delay, when enabled
  bit   auto_en   = 1'b0;
  int   dda_delay = 0;    // negative selects a random delay per segment
  bit   pend      = 1'b0;
  int   cnt       = 0;

  always @(negedge CLK) begin
    done_auto = 1'b0;
    if (!resetn || dda_abort) begin
      pend = 1'b0;
    end else if (dda_load) begin
      pend = 1'b1;
      cnt  = (dda_delay < 0) ? int'($urandom_range(0, 6)) : dda_delay;
    end else if (pend) begin
      if (cnt > 0) cnt = cnt - 1;
      else if (auto_en) begin
        done_auto = 1'b1;
        pend      = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic do_write(input logic [31:0] t, input logic [31:0] i,
                          input logic [31:0] ii, input logic d);
    bit ok = 1'b0;
    seg_t s;
    wr_valid = 1'b1; wr_ticks = t; wr_inc = i; wr_incinc = ii; wr_dir = d;
    for (int k = 0; k < 50 && !ok; k++) begin
      #4;
      if (wr_ready) begin
        ok = 1'b1;
        if (t != 0) begin
          s.ticks = t; s.inc = i; s.incinc = ii; s.dir = d;
          exp_q.push_back(s);
        end
      end
      @(negedge CLK);
    end
    wr_valid = 1'b0;
    if (!ok) check("write_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle(input int max_cyc);
    bit ok = 1'b0;
    for (int k = 0; k < max_cyc && !ok; k++) begin
      @(negedge CLK);
      if (!busy && exp_q.size() == 0 && !pend) ok = 1'b1;
    end
    if (!ok) check("idle_timeout", 64'd0, 64'd1);
    @(negedge CLK);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fill"},   64'(fill_level), 64'd0);
    check({tag, "_busy"},   64'(busy),       64'd0);
    check({tag, "_dtr"},    64'(buffer_dtr), 64'd1);
    check({tag, "_ready"},  64'(wr_ready),   64'd1);
    check({tag, "_pulses"}, 64'({dda_load, dda_abort, move_done}), 64'd0);
    check({tag, "_fields"}, 64'({dda_ticks, dda_inc} | 64'({dda_incinc, dda_dir})), 64'd0);
  endtask

  task automatic check_load_latency(input string tag, input logic [31:0] t, input logic d);
    check({tag, "_lat0"}, 64'(dda_load), 64'd0);
    @(negedge CLK);
    check({tag, "_lat1"}, 64'(dda_load), 64'd0);
    @(negedge CLK);
    check({tag, "_lat2"},  64'(dda_load),  64'd1);
    check({tag, "_ticks"}, 64'(dda_ticks), 64'(t));
    check({tag, "_dir"},   64'(dda_dir),   64'(d));
  endtask

  initial begin
    int b_loads, b_done, b_abort, nz;
    logic [31:0] t;
    seg_t s;

    resetn = 1'b0; halt = 1'b0; wr_valid = 1'b0;
    wr_ticks = '0; wr_inc = '0; wr_incinc = '0; wr_dir = 1'b0;

    fork
      forever begin
        @(negedge CLK);
        if (resetn) begin
          if (dda_load) begin
            if (exp_q.size() == 0) begin
              check("load_unexpected", 64'd1, 64'd0);
            end else begin
              s = exp_q.pop_front();
              check("load_ticks",  64'(dda_ticks),  64'(s.ticks));
              check("load_inc",    64'(dda_inc),    64'(s.inc));
              check("load_incinc", 64'(dda_incinc), 64'(s.incinc));
              check("load_dir",    64'(dda_dir),    64'(s.dir));
            end
            n_loads++;
          end
          if (move_done) n_done++;
          if (dda_abort) n_abort++;
        end
      end
    join_none

    #1 check_reset_outputs("reset");
    repeat (2) @(negedge CLK);
    resetn = 1'b1;
    @(negedge CLK);

    // single segment, DDA completes 100 cycles after load
    auto_en = 1'b1; dda_delay = 100;
    b_loads = n_loads; b_done = n_done;
    do_write(32'd100, 32'd5, 32'd0, 1'b1);
    check_load_latency("single", 32'd100, 1'b1);
    wait_idle(300);
    check("single_loads", 64'(n_loads - b_loads), 64'd1);
    check("single_done",  64'(n_done - b_done),   64'd1);
    check("single_busy",  64'(busy), 64'd0);

    // fill to full with DDA stalled; third write coincides with the first pop
    auto_en = 1'b0;
    b_loads = n_loads; b_done = n_done;
    do_write(32'd11, 32'd1, 32'd2, 1'b0);
    check("fill_1", 64'(fill_level), 64'd1);
    do_write(32'd12, 32'd3, 32'd4, 1'b1);
    check("fill_2", 64'(fill_level), 64'd2);
    do_write(32'd13, 32'd5, 32'd6, 1'b0);
    check("push_pop_same_cycle", 64'(fill_level), 64'd2);
    do_write(32'd14, 32'd7, 32'd8, 1'b1);
    check("fill_3", 64'(fill_level), 64'd3);
    do_write(32'd15, 32'd9, 32'd10, 1'b0);
    check("fill_full", 64'(fill_level), 64'd4);
    check("full_dtr",   64'(buffer_dtr), 64'd0);
    check("full_ready", 64'(wr_ready),   64'd0);
    wr_valid = 1'b1; wr_ticks = 32'd16; wr_inc = 32'd11; wr_incinc = 32'd12; wr_dir = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      check("held_fill", 64'(fill_level), 64'd4);
    end
    done_man = 1'b1;
    @(negedge CLK);
    done_man = 1'b0;
    check("held_done",  64'(move_done),  64'd1);
    check("held_fill4", 64'(fill_level), 64'd4);
    check("held_nrdy",  64'(wr_ready),   64'd0);
    @(negedge CLK);
    check("held_pop_fill", 64'(fill_level), 64'd3);
    check("held_pop_load", 64'(dda_load),   64'd1);
    check("held_rdy",      64'(wr_ready),   64'd1);
    s.ticks = 32'd16; s.inc = 32'd11; s.incinc = 32'd12; s.dir = 1'b1;
    exp_q.push_back(s);
    @(negedge CLK);
    wr_valid = 1'b0;
    check("held_accepted", 64'(fill_level), 64'd4);
    auto_en = 1'b1; dda_delay = -1;
    wait_idle(500);
    check("full_loads", 64'(n_loads - b_loads), 64'd6);
    check("full_done",  64'(n_done - b_done),   64'd6);

    // random segments including zero-tick ones; pointers wrap several times
    b_loads = n_loads; b_done = n_done; nz = 0;
    for (int k = 0; k < 14; k++) begin
      t = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom_range(1, 1000);
      if (t != 0) nz++;
      do_write(t, $urandom, $urandom, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end
    wait_idle(1000);
    check("rand_loads", 64'(n_loads - b_loads), 64'(nz));
    check("rand_done",  64'(n_done - b_done),   64'(nz));

    // zero-tick segment is skipped without load or move_done
    b_loads = n_loads; b_done = n_done;
    do_write(32'd50, 32'd1, 32'd0, 1'b0);
    do_write(32'd0,  32'd2, 32'd0, 1'b1);
    do_write(32'd30, 32'd3, 32'd0, 1'b0);
    wait_idle(300);
    check("zero_loads", 64'(n_loads - b_loads), 64'd2);
    check("zero_done",  64'(n_done - b_done),   64'd2);

    // halt during RUN with three entries queued
    auto_en = 1'b0;
    b_done = n_done; b_abort = n_abort;
    for (int k = 0; k < 4; k++) do_write(32'(20 + k), 32'(k), 32'd1, 1'b0);
    check("halt_pre_fill", 64'(fill_level), 64'd3);
    halt = 1'b1;
    exp_q.delete();
    wr_valid = 1'b1; wr_ticks = 32'd99;
    #1 check("halt_ready_low", 64'(wr_ready), 64'd0);
    @(negedge CLK);
    check("halt_abort", 64'(dda_abort),  64'd1);
    check("halt_flush", 64'(fill_level), 64'd0);
    check("halt_nodone", 64'(move_done), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check("halt_reject", 64'({fill_level, wr_ready, dda_abort}), 64'd0);
    end
    halt = 1'b0; wr_valid = 1'b0;
    @(negedge CLK);
    check("halt_idle", 64'({busy, wr_ready}), 64'b01);
    do_write(32'd77, 32'd4, 32'd5, 1'b1);
    check_load_latency("post_halt", 32'd77, 1'b1);
    auto_en = 1'b1;
    wait_idle(300);
    check("halt_abort_cnt", 64'(n_abort - b_abort), 64'd1);
    check("halt_done_cnt",  64'(n_done - b_done),   64'd1);

    // dda_done coincident with halt: abort wins, no move_done
    auto_en = 1'b0;
    do_write(32'd40, 32'd1, 32'd1, 1'b0);
    repeat (2) @(negedge CLK);
    halt = 1'b1; done_man = 1'b1;
    @(negedge CLK);
    check("coinc_nodone", 64'(move_done), 64'd0);
    check("coinc_abort",  64'(dda_abort), 64'd1);
    halt = 1'b0; done_man = 1'b0;
    exp_q.delete();
    @(negedge CLK);
    check("coinc_idle", 64'(busy), 64'd0);

    // asynchronous reset in the middle of a segment
    for (int k = 0; k < 3; k++) do_write(32'(60 + k), 32'd9, 32'd9, 1'b1);
    @(negedge CLK);
    check("prereset_busy", 64'(busy), 64'd1);
    #2 resetn = 1'b0;
    #1 check_reset_outputs("async_reset");
    exp_q.delete();
    @(negedge CLK);
    resetn = 1'b1;
    @(negedge CLK);
    check("post_reset_fill", 64'(fill_level), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
